// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT output reorder buffer.
//   FFT_WIDTH  : default width of one real/imag component
//   FFT_LOG_N  : default log2 of the frame length
//   ST_IDLE/ST_READ : read-side FSM encodings
//   bitrev()   : reverses the low 'bits' bits of k (bits <= 16)
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_LOG_N = 6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Bits at and above 'bits' come back as zero, so callers can truncate the
  // result to the frame address width with a size cast.
  function automatic logic [15:0] bitrev(input logic [15:0] k, input int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) r[i] = k[4'(bits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// -----------------------------------------------------------------------------
// reorder_ram
// Simple dual-port RAM: one write port, one read port, synchronous read with
// one cycle of latency. Contents are never cleared.
//   clock : write and read clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled every cycle
//   rdata : registered read data for the address sampled on the previous edge
// -----------------------------------------------------------------------------
module reorder_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder_buffer.sv
// -----------------------------------------------------------------------------
// fft_reorder_buffer
// Converts frames of N = 2**LOG_N complex samples arriving in bit-reversed order
// into natural order using two RAM banks in ping-pong fashion.
//
// Ports:
//   clock         : sole clock, rising edge
//   reset         : synchronous, active-high
//   di_en         : input sample valid (no ready; a sample is taken every
//                   cycle di_en is high, di_re/di_im are ignored otherwise)
//   di_re, di_im  : input sample, bit-reversed frame order
//   do_en         : output sample valid, N consecutive cycles per frame
//   do_re, do_im  : output sample, natural order, zero while do_en is low
//   do_last       : only when FFT_REORDER_LAST_EN is defined; marks the N-th
//                   output sample of each frame
//
// Handshake: di_en/do_en are pure valid strobes with no backpressure. The first
// do_en of a frame appears two cycles after the cycle carrying its last di_en
// (one cycle of synchronous RAM read, one of output register).
//
// The read FSM is visible as the internal signal 'state' (ST_IDLE/ST_READ).
// -----------------------------------------------------------------------------
import fft_pkg::*;

module fft_reorder_buffer #(
  parameter int WIDTH = FFT_WIDTH,
  parameter int LOG_N = FFT_LOG_N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
`ifdef FFT_REORDER_LAST_EN
  ,
  output logic             do_last
`endif
);

  logic [LOG_N-1:0]   wr_k;
  logic [LOG_N-1:0]   rev_k;
  logic               wr_bank;
  logic [LOG_N-1:0]   rd_cnt;
  logic               rd_bank;
  logic [0:0]         state;
  logic               frame_done;
  logic [2*WIDTH-1:0] rd_data;

  // The sample completing a frame is being accepted this cycle.
  assign frame_done = di_en && (&wr_k);

  always_comb rev_k = LOG_N'(bitrev(16'(wr_k), LOG_N));

  reorder_ram #(
    .DATA_W (2 * WIDTH),
    .ADDR_W (LOG_N + 1)
  ) u_ram (
    .clock (clock),
    .we    (di_en && !reset),
    .waddr ({wr_bank, rev_k}),
    .wdata ({di_re, di_im}),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_k    <= '0;
      wr_bank <= 1'b0;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      state   <= ST_IDLE;
      do_en   <= 1'b0;
`ifdef FFT_REORDER_LAST_EN
      do_last <= 1'b0;
`endif
    end else begin
      // Write side: k only advances on accepted samples, so gaps just stall it.
      if (di_en) begin
        wr_k <= wr_k + LOG_N'(1);
        if (&wr_k) wr_bank <= ~wr_bank;
      end

      // Read side: the bank just completed is wr_bank before it toggles.
      case (state)
        ST_IDLE: begin
          if (frame_done) begin
            state   <= ST_READ;
            rd_bank <= wr_bank;
            rd_cnt  <= '0;
          end
        end
        ST_READ: begin
          rd_cnt <= rd_cnt + LOG_N'(1);
          if (&rd_cnt) begin
            // A frame finishing on the last read address chains straight on
            // into the other bank so back-to-back frames leave no gap.
            if (frame_done) rd_bank <= wr_bank;
            else            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Aligned with the RAM's one-cycle read latency.
      do_en <= (state == ST_READ);
`ifdef FFT_REORDER_LAST_EN
      do_last <= (state == ST_READ) && (&rd_cnt);
`endif
    end
  end

  assign do_re = do_en ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign do_im = do_en ? rd_data[WIDTH-1:0]       : '0;

endmodule

// File: doc/fft_reorder_buffer.md
FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width per real/imag component (two's complement).
REQ-002 SHALL have parameter LOG_N, default 6, log2 of frame length N (N = 64 by default).
REQ-003 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port di_en  input  1  input sample valid.
REQ-006 SHALL have port di_re  input  WIDTH  input real part, bit-reversed frame order.
REQ-007 SHALL have port di_im  input  WIDTH  input imag part, bit-reversed frame order.
REQ-008 SHALL have port do_en  output  1  output sample valid.
REQ-009 SHALL have port do_re  output  WIDTH  output real part, natural order.
REQ-010 SHALL have port do_im  output  WIDTH  output imag part, natural order.

Function
REQ-011 SHALL consume one sample per clock when di_en=1; no backpressure, no ready signal.
REQ-012 SHALL count accepted samples with a LOG_N-bit write counter k; sample k written to address bitrev(k) of current write bank.
REQ-013 SHALL use two banks of N entries (ping-pong); write bank toggles when k wraps from N-1 to 0.
REQ-014 SHALL start readout of a completed bank on the cycle after its last write; read FSM states IDLE -> READ on frame complete, READ -> IDLE after address N-1 unless another frame completed at that exact cycle, in which case READ continues on the other bank with no gap.
REQ-015 SHALL read addresses 0..N-1 consecutively, one per cycle, no gaps regardless of input gaps.
REQ-016 SHALL assert first do_en exactly 2 cycles after the cycle carrying the last di_en of a frame (synchronous RAM read + output register).
REQ-017 SHALL drive do_en high for exactly N consecutive cycles per frame.
REQ-018 SHALL drive do_re/do_im to 0 whenever do_en=0.
REQ-019 SHALL pass data bit-exact: no scaling, rounding, or saturation; full range -2^(WIDTH-1)..2^(WIDTH-1)-1 preserved.
REQ-020 SHALL tolerate di_en gaps of any length mid-frame; k holds during gaps.
REQ-021 SHALL, at one input sample per cycle sustained, never overwrite a bank before it is fully read (ping-pong guarantees N-cycle separation).
REQ-022 SHALL ignore di_re/di_im when di_en=0.

Reset
REQ-023 SHALL on reset clear write counter, read counter, bank selects, FSM to IDLE, do_en/do_re/do_im to 0 on the next edge.
REQ-024 SHALL on reset mid-frame or mid-readout discard all partial and pending frames; RAM contents not cleared.
REQ-025 SHALL treat the first di_en after reset deasserts as sample k=0 of a new frame.

Configuration
REQ-026 SHALL, with macro FFT_REORDER_LAST_EN defined, add output do_last (1 bit), high together with the N-th do_en of each frame, 0 otherwise and after reset.
REQ-027 SHALL, without FFT_REORDER_LAST_EN, omit the do_last port entirely; all other behaviour identical.

Structure
REQ-028 SHALL place default WIDTH, default LOG_N, and the bit-reverse function in shared package fft_pkg.
REQ-029 SHALL instantiate one sub-module reorder_ram: simple dual-port (1 write, 1 read), 2N x 2*WIDTH, synchronous read, one-cycle latency.
REQ-030 SHALL keep FSM, counters, bank selects and output register in fft_reorder_buffer.

Verification
REQ-031 Ramp: 64 consecutive di_en, di_re=bitrev(k), di_im=-bitrev(k) -> do_re=0..63, do_im=0..-63, first do_en 2 cycles after last di_en.
REQ-032 Back-to-back: two frames, 128 consecutive di_en -> 128 consecutive do_en, no gap, frame 2 in natural order.
REQ-033 Gapped input: di_en toggling 1/0 over 128 cycles -> single contiguous 64-cycle do_en burst, correct order.
REQ-034 Reset at input sample 30, then full frame -> no output from partial frame; next frame output correct, starts 2 cycles after its last di_en.
REQ-035 Extremes: inputs -32768 and 32767 at WIDTH=16 -> identical values at natural positions, no sign corruption.
REQ-036 With FFT_REORDER_LAST_EN: ramp frame -> do_last high only on output index 63.
